// File: rtl/adc_ch_stream_fifo_pkg.sv
// Shared constants and state encoding for the ADC channel stream FIFO.
package adc_stream_pkg;

    localparam int unsigned SAMPLE_W         = 8;
    localparam int unsigned WORD_W           = 32;
    localparam int unsigned SAMPLES_PER_WORD = 4;
    localparam int unsigned BCNT_W           = $clog2(SAMPLES_PER_WORD);
    localparam int unsigned PACK_W           = SAMPLE_W * (SAMPLES_PER_WORD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAP   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/adc_ch_stream_fifo_if.sv
// Standard-FIFO read stream between the capture stage and the host core.
interface adc_ch_stream_fifo_if;
    import adc_stream_pkg::*;

    logic              user_r_read_open;
    logic              user_r_read_rden;
    logic [WORD_W-1:0] user_r_read_data;
    logic              user_r_read_empty;
    logic              user_r_read_eof;

    // Core side: opens the file and strobes reads.
    modport master (
        output user_r_read_open,
        output user_r_read_rden,
        input  user_r_read_data,
        input  user_r_read_empty,
        input  user_r_read_eof
    );

    // Capture side: serves words and end-of-stream.
    modport slave (
        input  user_r_read_open,
        input  user_r_read_rden,
        output user_r_read_data,
        output user_r_read_empty,
        output user_r_read_eof
    );

endinterface

// File: rtl/adc_ch_stream_fifo_fifo.sv
// Single-clock standard-read FIFO: one-cycle read latency, synchronous clear.
module sync_fifo_std #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] dout_q;
    logic          empty_q;
    logic          wr_ok, rd_ok;

    // Full is judged on the current count, before any same-cycle pop.
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty_q;

    // Next occupancy; clear dominates.
    always_comb begin
        count_d = count_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (clr) count_d = '0;
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= din;
    end

    // Pointers, occupancy, registered empty and read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            dout_q  <= '0;
        end else begin
            if (rd_ok) dout_q <= mem_q[rptr_q];
            if (clr) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (wr_ok) wptr_q <= wptr_q + 1'b1;
                if (rd_ok) rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

    assign dout  = dout_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/adc_ch_stream_fifo.sv
// ADC channel capture: packs 8-bit samples into 32-bit words, buffers them and
// serves them on a standard-FIFO read stream with length control and eof.
// Optional: define ADC_TEST_PATTERN_EN to add a test_mode counter source.
module adc_ch_stream_fifo
    import adc_stream_pkg::*;
#(
    parameter int unsigned FIFO_AW = 10,
    parameter int unsigned LEN_W   = 24
) (
    input  logic                bus_clk,
    input  logic                bus_rst,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic [LEN_W-1:0]    capture_len,
`ifdef ADC_TEST_PATTERN_EN
    input  logic                test_mode,
`endif
    adc_ch_stream_fifo_if.slave rd_if,
    output logic                overflow,
    output logic [FIFO_AW:0]    fill_level
);
    state_t              state_q, state_d;
    logic                open_q;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    wcnt_q, wcnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [PACK_W-1:0]   pack_q, pack_d;
    logic                ovf_q, ovf_d;
    logic                eof_q, eof_d;
    logic                open_rise_c, clr_c, push_c;
    logic [WORD_W-1:0]   push_word_c;
    logic [SAMPLE_W-1:0] sample_c;
    logic                fifo_full, fifo_empty;
    logic [WORD_W-1:0]   fifo_dout;
    logic [FIFO_AW:0]    fifo_count;
`ifdef ADC_TEST_PATTERN_EN
    logic [SAMPLE_W-1:0] tp_q, tp_d;

    assign sample_c = test_mode ? tp_q : adc_data;
`else
    assign sample_c = adc_data;
`endif

    assign open_rise_c = rd_if.user_r_read_open && !open_q;
    assign clr_c       = !rd_if.user_r_read_open;

    // Session FSM, packer and length counter next-state.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wcnt_d      = wcnt_q;
        bcnt_d      = bcnt_q;
        pack_d      = pack_q;
        ovf_d       = ovf_q;
        push_c      = 1'b0;
        push_word_c = '0;
`ifdef ADC_TEST_PATTERN_EN
        tp_d        = tp_q;
`endif
        unique case (state_q)
            IDLE: begin
                bcnt_d = '0;
                pack_d = '0;
                if (open_rise_c) begin
                    len_d   = capture_len;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = CAP;
`ifdef ADC_TEST_PATTERN_EN
                    tp_d    = '0;
`endif
                end
            end
            CAP: begin
                if (adc_valid) begin
`ifdef ADC_TEST_PATTERN_EN
                    tp_d = tp_q + 1'b1;
`endif
                    if (bcnt_q == BCNT_W'(SAMPLES_PER_WORD - 1)) begin
                        push_c      = 1'b1;
                        push_word_c = {sample_c, pack_q};
                        bcnt_d      = '0;
                        pack_d      = '0;
                        if (fifo_full) begin
                            ovf_d   = 1'b1;
                            state_d = DRAIN;
                        end else begin
                            wcnt_d = wcnt_q + 1'b1;
                            if ((len_q != '0) && (wcnt_d == len_q)) state_d = DRAIN;
                        end
                    end else begin
                        pack_d[{bcnt_q, 3'b000} +: SAMPLE_W] = sample_c;
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                bcnt_d = '0;
                pack_d = '0;
                if (fifo_empty) state_d = DONE;
            end
            DONE: begin
                bcnt_d = '0;
                pack_d = '0;
            end
            default: state_d = IDLE;
        endcase
        // Closing the file always wins, even over a completing push.
        if (!rd_if.user_r_read_open) begin
            state_d = IDLE;
            bcnt_d  = '0;
            pack_d  = '0;
            ovf_d   = ovf_q;
        end
        eof_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            state_q <= IDLE;
            open_q  <= 1'b0;
            len_q   <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            pack_q  <= '0;
            ovf_q   <= 1'b0;
            eof_q   <= 1'b0;
`ifdef ADC_TEST_PATTERN_EN
            tp_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            open_q  <= rd_if.user_r_read_open;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            pack_q  <= pack_d;
            ovf_q   <= ovf_d;
            eof_q   <= eof_d;
`ifdef ADC_TEST_PATTERN_EN
            tp_q    <= tp_d;
`endif
        end
    end

    sync_fifo_std #(
        .AW (FIFO_AW),
        .DW (WORD_W)
    ) u_fifo (
        .clk   (bus_clk),
        .rst   (bus_rst),
        .clr   (clr_c),
        .wr_en (push_c),
        .din   (push_word_c),
        .rd_en (rd_if.user_r_read_rden),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign rd_if.user_r_read_data  = fifo_dout;
    assign rd_if.user_r_read_empty = fifo_empty;
    assign rd_if.user_r_read_eof   = eof_q;
    assign overflow                = ovf_q;
    assign fill_level              = fifo_count;

endmodule

// File: tb/tb_adc_ch_stream_fifo.sv
// Bench for adc_ch_stream_fifo: queue-based reference model checked every
// cycle, a table of capture vectors, and hand-built corner sequences.
module tb_adc_ch_stream_fifo;

    localparam int unsigned DEPTH = 1024;

    logic        bus_clk = 1'b0;
    logic        bus_rst;
    logic        adc_valid;
    logic [7:0]  adc_data;
    logic [23:0] capture_len;
`ifdef ADC_TEST_PATTERN_EN
    logic        test_mode;
`endif
    logic        overflow;
    logic [10:0] fill_level;

    adc_ch_stream_fifo_if rif();

    adc_ch_stream_fifo dut (
        .bus_clk     (bus_clk),
        .bus_rst     (bus_rst),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .capture_len (capture_len),
`ifdef ADC_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .rd_if       (rif),
        .overflow    (overflow),
        .fill_level  (fill_level)
    );

    always #5 bus_clk = ~bus_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [31:0] mq[$];
    logic [7:0]  mb[$];
    bit          m_cap, m_started, m_ovf, m_eof, m_prev_open;
    int unsigned m_len, m_wcnt;
    logic [31:0] m_data;
    logic [7:0]  m_tp;

    typedef struct {
        logic [23:0] len;
        logic [7:0]  base;
        int          nbytes;
        int          words;
        logic [31:0] first;
        logic [31:0] last;
        logic        eof;
    } vec_t;

    vec_t vt[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mb.delete();
        m_cap = 0; m_started = 0; m_ovf = 0; m_eof = 0; m_prev_open = 0;
        m_len = 0; m_wcnt = 0; m_data = '0; m_tp = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit          full_b  = (mq.size() == DEPTH);
        bit          ended_b = m_started && !m_cap;
        int          sz_b    = mq.size();
        logic [7:0]  s;
        logic [31:0] w;
`ifdef ADC_TEST_PATTERN_EN
        s = test_mode ? m_tp : adc_data;
`else
        s = adc_data;
`endif
        if (rif.user_r_read_rden && sz_b > 0) m_data = mq.pop_front();
        if (!rif.user_r_read_open) begin
            mq.delete(); mb.delete();
            m_cap = 0; m_started = 0; m_eof = 0;
        end else if (!m_prev_open) begin
            m_cap = 1; m_started = 1; m_len = 32'(capture_len);
            m_wcnt = 0; m_ovf = 0; m_eof = 0; m_tp = '0;
            mb.delete();
        end else begin
            if (m_cap && adc_valid) begin
                mb.push_back(s);
                m_tp = m_tp + 8'd1;
                if (mb.size() == 4) begin
                    w = 32'(mb[0]) + 32'(mb[1]) * 256 + 32'(mb[2]) * 65536 + 32'(mb[3]) * 16777216;
                    mb.delete();
                    if (full_b) begin
                        m_ovf = 1; m_cap = 0;
                    end else begin
                        mq.push_back(w);
                        m_wcnt = (m_wcnt + 1) % 32'h0100_0000;
                        if (m_len != 0 && m_wcnt == m_len) m_cap = 0;
                    end
                end
            end
            if (!m_cap) mb.delete();
            m_eof = m_eof || (ended_b && sz_b == 0);
        end
        m_prev_open = rif.user_r_read_open;
    endtask

    // One clock: step model, let the edge happen, compare all outputs.
    task automatic cycle();
        logic [45:0] act, exp;
        model_step();
        @(posedge bus_clk);
        #1;
        act = {rif.user_r_read_data, rif.user_r_read_empty, rif.user_r_read_eof, overflow, fill_level};
        exp = {m_data, (mq.size() == 0), m_eof, m_ovf, 11'(mq.size())};
        check("model", 64'(act), 64'(exp));
    endtask

    task automatic do_reset();
        bus_rst = 1'b1;
        adc_valid = 1'b0; adc_data = '0; capture_len = '0;
        rif.user_r_read_open = 1'b0; rif.user_r_read_rden = 1'b0;
        model_reset();
        repeat (2) @(posedge bus_clk);
        #1;
        bus_rst = 1'b0;
    endtask

    task automatic close_session();
        rif.user_r_read_open = 1'b0;
        adc_valid = 1'b0;
        rif.user_r_read_rden = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic open_session(input logic [23:0] len);
        capture_len = len;
        rif.user_r_read_open = 1'b1;
        cycle();
    endtask

    task automatic feed(input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            adc_valid = 1'b1;
            adc_data  = base + 8'(k);
            cycle();
        end
        adc_valid = 1'b0;
    endtask

    task automatic read_all(output int n, output logic [31:0] first, output logic [31:0] last);
        n = 0; first = '0; last = '0;
        for (int g = 0; g < 1100 && rif.user_r_read_empty == 1'b0; g++) begin
            rif.user_r_read_rden = 1'b1;
            cycle();
            rif.user_r_read_rden = 1'b0;
            if (n == 0) first = rif.user_r_read_data;
            last = rif.user_r_read_data;
            n++;
        end
    endtask

    initial begin
        int          n;
        logic [31:0] f, l;

        vt[0] = '{len: 24'd2, base: 8'h10, nbytes: 8,  words: 2, first: 32'h13121110, last: 32'h17161514, eof: 1'b1};
        vt[1] = '{len: 24'd1, base: 8'hA0, nbytes: 12, words: 1, first: 32'hA3A2A1A0, last: 32'hA3A2A1A0, eof: 1'b1};
        vt[2] = '{len: 24'd3, base: 8'hFE, nbytes: 14, words: 3, first: 32'h0100FFFE, last: 32'h09080706, eof: 1'b1};
        vt[3] = '{len: 24'd0, base: 8'h00, nbytes: 10, words: 2, first: 32'h03020100, last: 32'h07060504, eof: 1'b0};

`ifdef ADC_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        do_reset();
        check("rst_data",  64'(rif.user_r_read_data), 64'h0);
        check("rst_empty", 64'(rif.user_r_read_empty), 64'h1);
        check("rst_eof",   64'(rif.user_r_read_eof), 64'h0);
        check("rst_ovf",   64'(overflow), 64'h0);
        check("rst_fill",  64'(fill_level), 64'h0);

        // Table-driven captures.
        foreach (vt[i]) begin
            close_session();
            open_session(vt[i].len);
            feed(vt[i].nbytes, vt[i].base);
            cycle();
            read_all(n, f, l);
            cycle();
            cycle();
            check($sformatf("vec%0d_words", i), 64'(n), 64'(vt[i].words));
            check($sformatf("vec%0d_first", i), 64'(f), 64'(vt[i].first));
            check($sformatf("vec%0d_last", i), 64'(l), 64'(vt[i].last));
            check($sformatf("vec%0d_eof", i), 64'(rif.user_r_read_eof), 64'(vt[i].eof));
        end

        // Overflow in continuous mode, then drain to eof.
        close_session();
        open_session(24'd0);
        feed(4 * DEPTH + 4, 8'h00);
        check("ovf_fill", 64'(fill_level), 64'(DEPTH));
        check("ovf_flag", 64'(overflow), 64'h1);
        read_all(n, f, l);
        cycle();
        cycle();
        check("ovf_words", 64'(n), 64'(DEPTH));
        check("ovf_first", 64'(f), 64'h03020100);
        check("ovf_eof", 64'(rif.user_r_read_eof), 64'h1);
        check("ovf_eof_empty", 64'(rif.user_r_read_empty), 64'h1);

        // Push while full with a same-cycle pop: word still dropped.
        close_session();
        open_session(24'd0);
        feed(4 * DEPTH, 8'h40);
        check("full_fill", 64'(fill_level), 64'(DEPTH));
        check("full_noovf", 64'(overflow), 64'h0);
        feed(3, 8'h77);
        rif.user_r_read_rden = 1'b1;
        feed(1, 8'h7A);
        rif.user_r_read_rden = 1'b0;
        check("fullpop_fill", 64'(fill_level), 64'(DEPTH - 1));
        check("fullpop_ovf", 64'(overflow), 64'h1);

        // Close mid-capture, then reopen with fresh bytes only.
        close_session();
        open_session(24'd0);
        feed(23, 8'h50);
        rif.user_r_read_open = 1'b0;
        cycle();
        check("close_empty", 64'(rif.user_r_read_empty), 64'h1);
        check("close_fill", 64'(fill_level), 64'h0);
        check("close_eof", 64'(rif.user_r_read_eof), 64'h0);
        open_session(24'd0);
        feed(4, 8'hC0);
        cycle();
        rif.user_r_read_rden = 1'b1;
        cycle();
        rif.user_r_read_rden = 1'b0;
        check("reopen_word", 64'(rif.user_r_read_data), 64'hC3C2C1C0);

        // Asynchronous reset while draining.
        close_session();
        open_session(24'd2);
        feed(8, 8'h20);
        cycle();
        rif.user_r_read_rden = 1'b1;
        cycle();
        rif.user_r_read_rden = 1'b0;
        check("pre_rst_data", 64'(rif.user_r_read_data), 64'h23222120);
        #2;
        bus_rst = 1'b1;
        #1;
        check("arst_data",  64'(rif.user_r_read_data), 64'h0);
        check("arst_empty", 64'(rif.user_r_read_empty), 64'h1);
        check("arst_fill",  64'(fill_level), 64'h0);
        check("arst_eof",   64'(rif.user_r_read_eof), 64'h0);
        do_reset();

        // Randomized sessions against the model.
        for (int s = 0; s < 6; s++) begin
            close_session();
            open_session((s % 3 == 0) ? 24'd0 : 24'($urandom_range(1, 24)));
            for (int c = 0; c < 300; c++) begin
                adc_valid = 1'($urandom % 2);
                adc_data  = 8'($urandom);
                rif.user_r_read_rden = 1'(($urandom % 3) != 0);
                cycle();
            end
            if (capture_len != 0) begin
                for (int g = 0; g < 3000 && !rif.user_r_read_eof; g++) begin
                    adc_valid = 1'($urandom % 2);
                    adc_data  = 8'($urandom);
                    rif.user_r_read_rden = 1'b1;
                    cycle();
                end
                check($sformatf("rand%0d_eof", s), 64'(rif.user_r_read_eof), 64'h1);
            end
        end

`ifdef ADC_TEST_PATTERN_EN
        // Internal counter source.
        close_session();
        test_mode = 1'b1;
        open_session(24'd64);
        for (int c = 0; c < 260; c++) begin
            adc_valid = 1'b1;
            adc_data  = 8'($urandom);
            cycle();
        end
        adc_valid = 1'b0;
        read_all(n, f, l);
        cycle();
        cycle();
        check("tp_words", 64'(n), 64'd64);
        check("tp_first", 64'(f), 64'h03020100);
        check("tp_last",  64'(l), 64'hFFFEFDFC);
        check("tp_eof",   64'(rif.user_r_read_eof), 64'h1);
        test_mode = 1'b0;
`endif

        close_session();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
